spi_master_ctrl: RTL

//   SPI controller (master) for the memory-backed SPI peripheral. Generates CS, SCLK and MOSI,
//   and samples MISO to run one 16-bit transaction per request: 7-bit address, R/W bit, 8-bit data.

---
 rtl/spi_master_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   Host-side SPI master (mode 0) running one transaction per request.
//   Frame, MSB first: {addr[ADDR_W-1:0], rw, data[DATA_W-1:0]}.
//   SCLK half-period is CLK_DIV clk cycles.
//
//   Optional build macro SPI_MASTER_MISO_SYNC_EN:
//     when defined, miso passes through a 2-flop synchronizer before it is sampled.
//     This option needs CLK_DIV >= 3.
//
// Ports
//   clk    system clock (posedge)      rst_n  synchronous active-low reset
//   start  request, taken when idle    rw     1 = read, 0 = write
//   addr   target address              wdata  write data (ignored for reads)
//   busy   transaction in flight       done   one-cycle end-of-transaction pulse
//   rdata  last read result            sclk   SPI clock, idle low
//   cs     chip select, active low     mosi   serial out
//   miso   serial in
//
// state | meaning
// IDLE  | waiting for start; cs high
// SETUP | cs low, first bit on mosi, sclk low for one half-period
// SHIFT | N bits, each a low half-period then a high half-period
// HOLD  | cs still low after the last sclk fall
// GAP   | cs high for at least one half-period before done
module spi_master_ctrl #(
    parameter int CLK_DIV = 16,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);

    localparam int N     = ADDR_W + 1 + DATA_W;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [N-1:0]       shreg_q, shreg_d;
    logic               rw_q, rw_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               done_q, done_d;
    logic               sclk_q, sclk_d;
    logic               cs_q, cs_d;
    logic               mosi_q, mosi_d;
    logic               miso_s;
    logic               tc;

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic [1:0] miso_sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) miso_sync_q <= '0;
        else        miso_sync_q <= {miso_sync_q[0], miso};
    end

    assign miso_s = miso_sync_q[1];
`else
    assign miso_s = miso;
`endif

    assign tc = (cnt_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = tc ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        rw_d    = rw_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_SETUP;
                    rw_d    = rw;
                    // Read frames carry zeros in the data field so mosi stays low there.
                    shreg_d = {addr, rw, (rw ? {DATA_W{1'b0}} : wdata)};
                    mosi_d  = addr[ADDR_W-1];
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    rx_d    = '0;
                end
            end
            S_SETUP: begin
                if (tc) begin
                    state_d = S_SHIFT;
                    bit_d   = '0;
                end
            end
            S_SHIFT: begin
                if (tc) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        // Only the data bits of a read carry peripheral output.
                        if (rw_q && (bit_q > BIT_W'(ADDR_W)))
                            rx_d = {rx_q[DATA_W-2:0], miso_s};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_W'(N - 1)) begin
                            state_d = S_HOLD;
                            mosi_d  = 1'b0;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shreg_d = shreg_q << 1;
                            mosi_d  = shreg_q[N-2];
                        end
                    end
                end
            end
            S_HOLD: begin
                if (tc) begin
                    state_d = S_GAP;
                    cs_d    = 1'b1;
                end
            end
            S_GAP: begin
                if (tc) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (rw_q) rdata_d = rx_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            rw_q    <= 1'b0;
            rx_q    <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            rw_q    <= rw_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign rdata = rdata_q;
    assign sclk  = sclk_q;
    assign cs    = cs_q;
    assign mosi  = mosi_q;

endmodule
